number_overlay_ctrl: RTL and testbench

- Sits directly upstream of the digit glyph ROM stage in the ISP overlay path.
- Accepts a binary measurement value and converts it to 4 BCD digits using a sequential shift-add-3 (double-dabble) engine.
- Holds the converted digits and commits them to the display only at frame start, so no frame shows a mix of old and new digits.
- Per pixel, drives the 4-bit digit code for the glyph column under pixel_x, plus a digit-enable flag.

---
 rtl/number_overlay_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_number_overlay_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/number_overlay_ctrl.sv
// ---------------------------------------------------------------------------
// number_overlay_ctrl
//
// Purpose:
//   Converts a 14-bit binary measurement into four BCD digits with a
//   sequential shift-add-3 (double-dabble) engine. The result is held in a
//   pending register and copied to the display register only on a rising
//   edge of vertical sync, so a frame never shows a mix of old and new
//   digits. For every pixel the block outputs the BCD digit of the glyph
//   cell under pixel_x together with a digit-enable flag. These outputs
//   feed the digit glyph ROM stage.
//
// Parameters:
//   X0      - left x of the 4-digit field (pixel units)
//   Y0      - top y of the field; the field covers rows Y0+1 .. Y0+32
//   GLYPH_W - width of one digit cell in pixels (power of 2)
//   LZB     - 1 = blank leading zeros (the units digit is always shown)
//
// Ports:
//   clk          in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   value_i      in   [13:0] binary value to display
//   value_valid  in   value_i is valid
//   value_ready  out  converter is idle and can accept a value
//   vs_i         in   vertical sync, active high
//   pixel_x      in   [11:0] current pixel column
//   pixel_y      in   [11:0] current pixel row
//   de           in   data enable
//   number_data  out  [3:0] BCD digit of the current pixel's cell
//   digit_en     out  current pixel lies in a shown digit cell
//   conv_done    out  one-cycle pulse when a conversion completes
//
// All outputs are registered. number_data/digit_en have a latency of one
// clock cycle relative to pixel_x/pixel_y/de.
// ---------------------------------------------------------------------------
module number_overlay_ctrl #(
    parameter int unsigned X0      = 0,
    parameter int unsigned Y0      = 50,
    parameter int unsigned GLYPH_W = 16,
    parameter int unsigned LZB     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] value_i,
    input  logic        value_valid,
    output logic        value_ready,
    input  logic        vs_i,
    input  logic [11:0] pixel_x,
    input  logic [11:0] pixel_y,
    input  logic        de,
    output logic [3:0]  number_data,
    output logic        digit_en,
    output logic        conv_done
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam int unsigned GLYPH_SHIFT = $clog2(GLYPH_W);

    // Window bounds widened to 13 bits so Y0+32 cannot overflow 12 bits.
    localparam logic [12:0] X_LO = 13'(X0);
    localparam logic [12:0] Y_LO = 13'(Y0);
    localparam logic [12:0] Y_HI = 13'(Y0 + 32);

    localparam logic [11:0] X0_12    = 12'(X0);
    localparam logic [3:0]  LAST_IT  = 4'd13;      // 14 iterations: 0..13
    localparam logic [13:0] MAX_BCD  = 14'd9999;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Add 3 to a BCD nibble of 5 or more so the following shift carries
    // correctly into the next decade.
    function automatic logic [3:0] add3_nibble(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    // One double-dabble iteration on the {BCD[15:0], BIN[13:0]} register:
    // adjust every BCD nibble, then shift the whole 30-bit word left by one.
    function automatic logic [29:0] dabble_step(input logic [29:0] sr);
        logic [29:0] adj;
        adj          = sr;
        adj[29:26]   = add3_nibble(sr[29:26]);
        adj[25:22]   = add3_nibble(sr[25:22]);
        adj[21:18]   = add3_nibble(sr[21:18]);
        adj[17:14]   = add3_nibble(sr[17:14]);
        return {adj[28:0], 1'b0};
    endfunction

    // Clamp an input value to the largest four-digit number.
    function automatic logic [13:0] saturate_value(input logic [13:0] v);
        logic [13:0] res;
        if (v > MAX_BCD) begin
            res = MAX_BCD;
        end else begin
            res = v;
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Converter state
    // -----------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } conv_state_e;

    conv_state_e state_q;
    logic [29:0] shift_q;
    logic [29:0] shift_d;
    logic [3:0]  iter_q;
    logic        ready_q;
    logic        done_q;
    logic        accept_s;
    logic        conv_last_s;

    // Pending / display storage
    logic [15:0] pend_q;
    logic        pend_flag_q;
    logic [15:0] disp_q;
    logic        vs_q;
    logic        vs_rise_s;
    logic        commit_s;

    // Pixel path
    logic [11:0] digit_pos_s;
    logic [1:0]  digit_idx_s;
    logic        x_ge_s;
    logic        in_win_s;
    logic [3:0]  digit_sel_s;
    logic        lead_zero_s;
    logic        blank_s;
    logic [3:0]  number_data_q;
    logic        digit_en_q;

    // Handshake, final-iteration and vsync-edge decode.
    always_comb begin
        accept_s    = value_valid && ready_q;
        conv_last_s = (state_q == ST_CONV) && (iter_q == LAST_IT);
        vs_rise_s   = vs_i && !vs_q;
        commit_s    = vs_rise_s && pend_flag_q;
        shift_d     = dabble_step(shift_q);
    end

    // Converter FSM: accepts a value, runs 14 dabble iterations, pulses done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= 30'd0;
            iter_q  <= 4'd0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (accept_s) begin
                        shift_q <= {16'd0, saturate_value(value_i)};
                        iter_q  <= 4'd0;
                        ready_q <= 1'b0;
                        state_q <= ST_CONV;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_CONV: begin
                    shift_q <= shift_d;
                    iter_q  <= iter_q + 4'd1;
                    if (conv_last_s) begin
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        ready_q <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Pending/display registers. A completion and a vsync edge on the same
    // cycle commit the old pending value; the new result waits one frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= 16'd0;
            pend_flag_q <= 1'b0;
            disp_q      <= 16'd0;
            vs_q        <= 1'b0;
        end else begin
            vs_q <= vs_i;
            if (conv_last_s) begin
                // Latest result wins, even if the previous one was never shown.
                pend_q      <= shift_d[29:14];
                pend_flag_q <= 1'b1;
            end else if (commit_s) begin
                pend_flag_q <= 1'b0;
            end
            if (commit_s) begin
                disp_q <= pend_q;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pixel path
    // -----------------------------------------------------------------------

    // Cell index. The offset is only meaningful when pixel_x >= X0, which
    // in_win_s enforces, so the wrap of the subtraction never matters.
    assign digit_pos_s = (pixel_x - X0_12) >> GLYPH_SHIFT;

    // Window decode, digit select and leading-zero detection for this pixel.
    always_comb begin
        x_ge_s      = ({1'b0, pixel_x} >= X_LO);
        in_win_s    = de && x_ge_s && (digit_pos_s < 12'd4) &&
                      ({1'b0, pixel_y} > Y_LO) && ({1'b0, pixel_y} <= Y_HI);
        digit_idx_s = digit_pos_s[1:0];
        digit_sel_s = 4'd0;
        lead_zero_s = 1'b0;
        case (digit_idx_s)
            2'd0: begin
                digit_sel_s = disp_q[15:12];
                lead_zero_s = (disp_q[15:12] == 4'd0);
            end
            2'd1: begin
                digit_sel_s = disp_q[11:8];
                lead_zero_s = (disp_q[15:8] == 8'd0);
            end
            2'd2: begin
                digit_sel_s = disp_q[7:4];
                lead_zero_s = (disp_q[15:4] == 12'd0);
            end
            2'd3: begin
                // Units digit is never blanked.
                digit_sel_s = disp_q[3:0];
                lead_zero_s = 1'b0;
            end
            default: begin
                digit_sel_s = 4'd0;
                lead_zero_s = 1'b0;
            end
        endcase
        blank_s = (LZB != 0) && lead_zero_s;
    end

    // Registered pixel outputs, one cycle behind the pixel coordinates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            number_data_q <= 4'd0;
            digit_en_q    <= 1'b0;
        end else if (in_win_s) begin
            number_data_q <= digit_sel_s;
            digit_en_q    <= !blank_s;
        end else begin
            number_data_q <= 4'd0;
            digit_en_q    <= 1'b0;
        end
    end

    assign value_ready = ready_q;
    assign conv_done   = done_q;
    assign number_data = number_data_q;
    assign digit_en    = digit_en_q;

endmodule

// File: tb/tb_number_overlay_ctrl.sv
// ---------------------------------------------------------------------------
// tb_number_overlay_ctrl
//
// Directed, table-driven bench for number_overlay_ctrl with X0=0, Y0=50,
// GLYPH_W=16, LZB=1. Pixel vectors {x, y, de, expected digit, expected en}
// are loaded into a table and replayed; handshake timing, the
// completion/vsync collision and reset mid-conversion are hand sequences.
// ---------------------------------------------------------------------------
module tb_number_overlay_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] value_i;
    logic        value_valid;
    logic        value_ready;
    logic        vs_i;
    logic [11:0] pixel_x;
    logic [11:0] pixel_y;
    logic        de;
    logic [3:0]  number_data;
    logic        digit_en;
    logic        conv_done;

    always #5 clk = ~clk;

    number_overlay_ctrl #(
        .X0(0), .Y0(50), .GLYPH_W(16), .LZB(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_i    (value_i),
        .value_valid(value_valid),
        .value_ready(value_ready),
        .vs_i       (vs_i),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .de         (de),
        .number_data(number_data),
        .digit_en   (digit_en),
        .conv_done  (conv_done)
    );

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic        de;
        logic [3:0]  nd;
        logic        en;
    } pix_vec_t;

    pix_vec_t pv[32];
    int       npv = 0;
    int       n_chk = 0;
    int       n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input int x, input int y, input int d,
                           input int nd, input int en);
        pv[npv].x  = 12'(x);
        pv[npv].y  = 12'(y);
        pv[npv].de = 1'(d);
        pv[npv].nd = 4'(nd);
        pv[npv].en = 1'(en);
        npv++;
    endtask

    // Replay the table: drive a pixel, clock once, compare the registered result.
    task automatic run_vecs(input string tag);
        for (int i = 0; i < npv; i++) begin
            pixel_x = pv[i].x;
            pixel_y = pv[i].y;
            de      = pv[i].de;
            tick();
            check($sformatf("%s[%0d].number_data", tag, i), int'(number_data), int'(pv[i].nd));
            check($sformatf("%s[%0d].digit_en", tag, i), int'(digit_en), int'(pv[i].en));
        end
        de  = 1'b0;
        npv = 0;
    endtask

    // Fill the table with both edges of every cell on row 51, plus x=64.
    task automatic cells(input string tag,
                         input int d0, input int d1, input int d2, input int d3,
                         input int e0, input int e1, input int e2, input int e3);
        add_vec(0,  51, 1, d0, e0);  add_vec(15, 51, 1, d0, e0);
        add_vec(16, 51, 1, d1, e1);  add_vec(31, 51, 1, d1, e1);
        add_vec(32, 51, 1, d2, e2);  add_vec(47, 51, 1, d2, e2);
        add_vec(48, 51, 1, d3, e3);  add_vec(63, 51, 1, d3, e3);
        add_vec(64, 51, 1, 0, 0);
        run_vecs(tag);
    endtask

    task automatic vs_pulse();
        vs_i = 1'b1;
        tick();
        vs_i = 1'b0;
        tick();
    endtask

    task automatic send(input int v);
        int k;
        k = 0;
        while (!value_ready && k < 40) begin
            tick();
            k++;
        end
        check("send_ready", int'(value_ready), 1);
        value_i     = 14'(v);
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!conv_done && k < 40) begin
            tick();
            k++;
        end
        check({tag, ".conv_done_seen"}, int'(conv_done), 1);
    endtask

    initial begin
        int low_cnt;
        int done_at;
        int done_cnt;

        rst_n       = 1'b0;
        value_i     = 14'd0;
        value_valid = 1'b0;
        vs_i        = 1'b0;
        pixel_x     = 12'd0;
        pixel_y     = 12'd0;
        de          = 1'b0;
        #12;
        check("rst.value_ready", int'(value_ready), 1);
        check("rst.conv_done",   int'(conv_done),   0);
        check("rst.number_data", int'(number_data), 0);
        check("rst.digit_en",    int'(digit_en),    0);
        #6 rst_n = 1'b1;
        tick();

        // Empty display: only the units cell is enabled.
        vs_pulse();
        cells("reset_disp", 0, 0, 0, 0, 0, 0, 0, 1);

        // 1234: ready low for exactly 14 cycles, done after 14 edges.
        send(1234);
        low_cnt  = (value_ready == 1'b0) ? 1 : 0;
        done_at  = -1;
        done_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (!value_ready) low_cnt++;
            if (conv_done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
        check("1234.ready_low_cycles", low_cnt, 14);
        check("1234.conv_done_cycle",  done_at, 14);
        check("1234.conv_done_pulses", done_cnt, 1);
        // Still pending: display unchanged until vsync.
        cells("1234_pre_vs", 0, 0, 0, 0, 0, 0, 0, 1);
        vs_pulse();
        cells("1234", 1, 2, 3, 4, 1, 1, 1, 1);
        add_vec(0, 50, 1, 0, 0);
        add_vec(0, 82, 1, 1, 1);
        add_vec(0, 83, 1, 0, 0);
        add_vec(20, 60, 0, 0, 0);
        run_vecs("1234_rows");

        // Saturation.
        send(12345);
        wait_done("12345");
        vs_pulse();
        cells("9999", 9, 9, 9, 9, 1, 1, 1, 1);

        // Leading-zero blanking.
        send(7);
        wait_done("7");
        vs_pulse();
        cells("0007", 0, 0, 0, 7, 0, 0, 0, 1);
        add_vec(48, 50, 1, 0, 0);
        add_vec(48, 83, 1, 0, 0);
        add_vec(48, 51, 0, 0, 0);
        add_vec(48, 83 - 1, 1, 7, 1);
        run_vecs("0007_rows");

        // 42 completes, then 815 completes on the very edge vsync rises.
        send(42);
        wait_done("42");
        send(815);
        for (int k = 0; k < 13; k++) tick();
        vs_i = 1'b1;
        tick();
        check("815.done_on_vs_edge", int'(conv_done), 1);
        vs_i = 1'b0;
        tick();
        cells("0042", 0, 0, 4, 2, 0, 0, 1, 1);
        vs_pulse();
        cells("0815", 0, 8, 1, 5, 0, 1, 1, 1);

        // Reset during conversion of 5555.
        send(5555);
        for (int k = 0; k < 7; k++) tick();
        check("midrst.ready_before", int'(value_ready), 0);
        rst_n = 1'b0;
        #1;
        check("midrst.value_ready", int'(value_ready), 1);
        check("midrst.number_data", int'(number_data), 0);
        check("midrst.digit_en",    int'(digit_en),    0);
        #2 rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (conv_done) done_cnt++;
        end
        check("midrst.no_conv_done", done_cnt, 0);
        cells("midrst_disp", 0, 0, 0, 0, 0, 0, 0, 1);
        vs_pulse();
        cells("midrst_after_vs", 0, 0, 0, 0, 0, 0, 0, 1);

        // Next value converts correctly, inner zero not blanked.
        send(3071);
        wait_done("3071");
        vs_pulse();
        cells("3071", 3, 0, 7, 1, 1, 1, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
